cordic_nco_sched: RTL and testbench
===================================

# cordic_nco_sched

Time-multiplexed scheduler that shares one `cordic` rotation pipeline between NCH independent NCO channels. Each channel has its own phase accumulator and programmable phase increment. The scheduler issues one channel's phase into the CORDIC per enabled clock in round-robin order. A tag pipeline tracks which channel each sample belongs to, so CORDIC results are returned tagged with their channel. The block sits between the CSR/config logic and the single shared `cordic` instance of the NCO subsystem.

## Interface
- NCH, 4: number of NCO channels (2..16)
- PW, 19: phase accumulator / increment width
- OW, 12: CORDIC output width
- CORDIC_LAT, 17: CORDIC pipeline latency in `ce` cycles (i_phase sample to o_xval/o_yval)
- clk  in  1  master clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  global enable; everything (scheduler, accumulators, tag pipe) advances only when 1
- ch_en  in  NCH  per-channel enable; channel takes part in round-robin when 1
- cfg_wr  in  1  config write strobe (single cycle, independent of `ce`)
- cfg_ch  in  clog2(NCH)  channel index for write
- cfg_sel  in  1  0 = increment register, 1 = phase offset register (only with macro)
- cfg_data  in  PW  value written
- sync  in  1  pulse; zeroes all phase accumulators
- cor_ce  out  1  drives cordic i_ce (= ce)
- cor_phase  out  PW  drives cordic i_phase
- cor_cos  in  OW  from cordic o_xval
- cor_sin  in  OW  from cordic o_yval
- out_valid  out  1  tagged result valid
- out_ch  out  clog2(NCH)  channel of result
- out_cos  out  OW  cosine sample
- out_sin  out  OW  sine sample

## Operation
- Registers: per-channel inc[NCH] and acc[NCH] (PW bits each), rr_ptr, and tag pipe of CORDIC_LAT+1 stages, each {valid, ch}.
- Scheduler, on each `ce` cycle: select the first enabled channel strictly after rr_ptr, wrapping modulo NCH. On selection:
  - cor_phase <= acc[sel]
  - acc[sel] <= acc[sel] + inc[sel], mod 2^PW
  - rr_ptr <= sel
  - push {1, sel} into the tag pipe
- If ch_en == 0, no selection: cor_phase holds, push {0, x}, rr_ptr unchanged.
- A single enabled channel is issued every `ce` cycle.
- Tag pipe shifts only when `ce`=1, exactly mirroring the CORDIC pipeline.
- Result path: out_valid = tail.valid & ce. out_ch = tail.ch. out_cos/out_sin = cor_cos/cor_sin (combinational pass-through, aligned by tag pipe depth).
- cfg_wr: inc[cfg_ch] <= cfg_data next edge.
  - If the same channel issues in the same cycle, the issue uses the old inc; the new inc applies from the channel's next issue.
- sync (when ce or not): all acc <= 0 next edge. Overrides a concurrent accumulate. In-flight tags are unaffected.
- Disabling a channel mid-flight: already-issued samples still emerge with out_valid.

## Timing
- Reset (reset_n low, async): acc=0, inc=0, rr_ptr=NCH-1 (so ch0 is first), tag pipe all invalid, cor_phase=0.
  - out_valid=0, out_ch=0. out_cos/out_sin follow the CORDIC.
- Latency: a channel selected in `ce` cycle n produces out_valid in `ce` cycle n+CORDIC_LAT+1. Cycles with ce=0 do not count.
- Throughput: 1 sample/`ce` cycle aggregate. With k channels enabled, each channel gets 1 sample every k `ce` cycles.
- Reset released mid-operation: first issue on the first `ce` edge after deassertion. No spurious out_valid for CORDIC_LAT+1 `ce` cycles.
- cfg_wr ignores `ce`. A write with cfg_ch >= NCH is dropped.

## Configuration
- CORDIC_NCO_PHASE_OFFSET_EN defined:
  - Adds per-channel off[NCH] register, written when cfg_wr & cfg_sel=1.
  - cor_phase <= acc[sel] + off[sel], mod 2^PW. Reset value of off is 0.
- Not defined:
  - No off registers; cfg_sel is ignored and writes always target inc.
  - cor_phase <= acc[sel].

## Test plan
- Reset, NCH=4, all enabled, inc = {100, 200, 300, 400}, ce=1 -> out_ch sequence 0,1,2,3,0,… starting 18 cycles after first issue. Channel 1's phases fed to cor_phase are 0, 200, 400.
- ch_en=4'b0101 -> issues alternate ch0/ch2. ch1 and ch3 accumulators stay constant. ch_en=0 -> no out_valid after the tag pipe drains.
- ce toggled 1,0,1,0 -> accumulators and tag pipe advance only on ce=1. Latency stays 18 `ce` cycles, and out_ch still matches the issued channel.
- inc[0]=2^PW-1 -> acc[0] wraps 0, 524287, 524286, …. Write inc[0]=5 in the same cycle ch0 issues -> that step still uses 524287, the next uses 5.
- sync pulse while ch2 is in flight -> all acc=0 next edge. The in-flight ch2 result is still delivered with out_ch=2. reset_n asserted mid-stream -> out_valid=0 immediately (async).
- With CORDIC_NCO_PHASE_OFFSET_EN, off[1]=131072 (90°) and inc[1]=0 -> ch1 cor_phase=131072 on every issue, and out_cos≈0, out_sin≈1760.

Source files
------------

// File: rtl/cordic_nco_sched.sv
`default_nettype none
// ============================================================================
// Module   : cordic_nco_sched
// Purpose  : Round-robin scheduler sharing one CORDIC rotation pipeline
//            between NCH NCO channels. Each channel owns a phase accumulator
//            and a phase increment. A tag pipe that mirrors the CORDIC depth
//            labels every returned sample with its channel.
// Ports    : clk, reset_n (async, active-low), ce (global advance enable)
//            ch_en           per-channel round-robin participation
//            cfg_wr/cfg_ch/cfg_sel/cfg_data   register write port (ignores ce)
//            sync            zeroes every phase accumulator
//            cor_ce/cor_phase -> CORDIC,  cor_cos/cor_sin <- CORDIC
//            out_valid/out_ch/out_cos/out_sin   tagged result
// Option   : CORDIC_NCO_PHASE_OFFSET_EN adds a per-channel phase offset
//            register selected by cfg_sel=1.
// Revision : 1.0  initial release
// ============================================================================
module cordic_nco_sched #(
   parameter int NCH        = 4,
   parameter int PW         = 19,
   parameter int OW         = 12,
   parameter int CORDIC_LAT = 17
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ce,
   input  logic [NCH-1:0]          ch_en,
   input  logic                    cfg_wr,
   input  logic [$clog2(NCH)-1:0]  cfg_ch,
   input  logic                    cfg_sel,
   input  logic [PW-1:0]           cfg_data,
   input  logic                    sync,
   output logic                    cor_ce,
   output logic [PW-1:0]           cor_phase,
   input  logic [OW-1:0]           cor_cos,
   input  logic [OW-1:0]           cor_sin,
   output logic                    out_valid,
   output logic [$clog2(NCH)-1:0]  out_ch,
   output logic [OW-1:0]           out_cos,
   output logic [OW-1:0]           out_sin
);
   localparam int c_cw        = $clog2(NCH);
   localparam int c_tag_depth = CORDIC_LAT + 1;

   logic [PW-1:0]   r_acc    [NCH];
   logic [PW-1:0]   r_inc    [NCH];
   logic [c_cw-1:0] r_rr;
   logic [PW-1:0]   r_phase;
   logic            r_tag_v  [c_tag_depth];
   logic [c_cw-1:0] r_tag_ch [c_tag_depth];

   logic            w_found;
   logic [c_cw-1:0] w_sel;
   logic            w_issue;
   logic            w_cfg_ok;
   logic            w_inc_wr;
   logic [PW-1:0]   w_phase_next;

   // First enabled channel strictly after r_rr, wrapping; offset NCH
   // revisits r_rr itself so a lone enabled channel issues every cycle.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = 1; i <= NCH; i++) begin
         int j;
         j = int'(r_rr) + i;
         if (j >= NCH) j = j - NCH;
         if (!w_found && ch_en[j]) begin
            w_found = 1'b1;
            w_sel   = c_cw'(j);
         end
      end
   end

   assign w_issue  = ce & w_found;
   // Only matters when NCH is not a power of two.
   assign w_cfg_ok = cfg_wr & ({1'b0, cfg_ch} < (c_cw+1)'(NCH));

`ifdef CORDIC_NCO_PHASE_OFFSET_EN
   logic [PW-1:0] r_off [NCH];
   logic          w_off_wr;

   assign w_inc_wr     = w_cfg_ok & ~cfg_sel;
   assign w_off_wr     = w_cfg_ok &  cfg_sel;
   assign w_phase_next = r_acc[w_sel] + r_off[w_sel];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) r_off[i] <= '0;
      end else if (w_off_wr) begin
         r_off[cfg_ch] <= cfg_data;
      end
   end
`else
   logic w_unused_cfg_sel;

   assign w_unused_cfg_sel = cfg_sel;
   assign w_inc_wr         = w_cfg_ok;
   assign w_phase_next     = r_acc[w_sel];
`endif

   // Accumulators, increments, scheduler pointer and issued phase.
   // The accumulate uses the pre-write increment, so a concurrent cfg write
   // only affects the channel's following issue; sync wins over accumulate.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_acc[i] <= '0;
            r_inc[i] <= '0;
         end
         r_rr    <= c_cw'(NCH - 1);
         r_phase <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (sync)
               r_acc[i] <= '0;
            else if (w_issue && (w_sel == c_cw'(i)))
               r_acc[i] <= r_acc[i] + r_inc[i];
            if (w_inc_wr && (cfg_ch == c_cw'(i)))
               r_inc[i] <= cfg_data;
         end
         if (w_issue) begin
            r_rr    <= w_sel;
            r_phase <= w_phase_next;
         end
      end
   end

   // Tag pipe: advances in lockstep with the CORDIC, i.e. only when ce=1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < c_tag_depth; i++) begin
            r_tag_v[i]  <= 1'b0;
            r_tag_ch[i] <= '0;
         end
      end else if (ce) begin
         r_tag_v[0]  <= w_found;
         r_tag_ch[0] <= w_found ? w_sel : '0;
         for (int i = 1; i < c_tag_depth; i++) begin
            r_tag_v[i]  <= r_tag_v[i-1];
            r_tag_ch[i] <= r_tag_ch[i-1];
         end
      end
   end

   assign cor_ce    = ce;
   assign cor_phase = r_phase;
   assign out_valid = r_tag_v[c_tag_depth-1] & ce;
   assign out_ch    = r_tag_ch[c_tag_depth-1];
   assign out_cos   = cor_cos;
   assign out_sin   = cor_sin;

endmodule
`default_nettype wire

// File: tb/tb_cordic_nco_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_nco_sched
// Purpose  : Scoreboard bench for cordic_nco_sched. A stand-in CORDIC (plain
//            delay line with a reversible phase->sample mapping) lets every
//            returned sample be traced back to the phase that was issued.
//            Honours CORDIC_NCO_PHASE_OFFSET_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_cordic_nco_sched;
   localparam int NCH = 4;
   localparam int PW  = 19;
   localparam int OW  = 12;
   localparam int L   = 17;
   localparam int CW  = $clog2(NCH);
`ifdef CORDIC_NCO_PHASE_OFFSET_EN
   localparam bit OFF_EN = 1'b1;
`else
   localparam bit OFF_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset_n;
   logic           ce;
   logic [NCH-1:0] ch_en;
   logic           cfg_wr;
   logic [CW-1:0]  cfg_ch;
   logic           cfg_sel;
   logic [PW-1:0]  cfg_data;
   logic           sync;
   logic           cor_ce;
   logic [PW-1:0]  cor_phase;
   logic [OW-1:0]  cor_cos;
   logic [OW-1:0]  cor_sin;
   logic           out_valid;
   logic [CW-1:0]  out_ch;
   logic [OW-1:0]  out_cos;
   logic [OW-1:0]  out_sin;

   cordic_nco_sched #(.NCH(NCH), .PW(PW), .OW(OW), .CORDIC_LAT(L)) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .ch_en(ch_en),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .sync(sync), .cor_ce(cor_ce), .cor_phase(cor_phase),
      .cor_cos(cor_cos), .cor_sin(cor_sin),
      .out_valid(out_valid), .out_ch(out_ch), .out_cos(out_cos), .out_sin(out_sin)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] f_cos(input logic [PW-1:0] ph);
      return ph[PW-1 -: OW];
   endfunction
   function automatic logic [OW-1:0] f_sin(input logic [PW-1:0] ph);
      return ph[OW-1:0] ^ 12'hA5A;
   endfunction

   // Stand-in CORDIC: samples cor_phase on each ce edge, L-deep delay line.
   logic [PW-1:0] fpipe [L];
   always @(posedge clk) begin
      if (cor_ce) begin
         fpipe[0] <= cor_phase;
         for (int k = 1; k < L; k++) fpipe[k] <= fpipe[k-1];
      end
   end
   assign cor_cos = f_cos(fpipe[L-1]);
   assign cor_sin = f_sin(fpipe[L-1]);

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      int            ch;
      logic [PW-1:0] ph;
   } exp_t;

   exp_t          q[$];
   logic [PW-1:0] m_acc [NCH];
   logic [PW-1:0] m_inc [NCH];
   logic [PW-1:0] m_off [NCH];
   int            m_rr;
   logic [PW-1:0] m_phase;
   int            m_cnt = 0;   // ce edges seen while out of reset

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_acc[c] = '0; m_inc[c] = '0; m_off[c] = '0;
      end
      m_rr    = NCH - 1;
      m_phase = '0;
      q.delete();
   endtask

   // Effect of the coming clock edge given the inputs now being driven.
   task automatic model_edge(input logic e, input logic [NCH-1:0] en, input logic wr,
                             input int wch, input logic [PW-1:0] wd, input logic ws,
                             input logic sy);
      if (e) begin
         m_cnt++;
         for (int j = 1; j <= NCH; j++) begin
            int c;
            c = (m_rr + j) % NCH;
            if (en[c]) begin
               m_phase = OFF_EN ? m_acc[c] + m_off[c] : m_acc[c];
               q.push_back('{due: m_cnt + L, ch: c, ph: m_phase});
               m_acc[c] = m_acc[c] + m_inc[c];
               m_rr     = c;
               break;
            end
         end
      end
      if (sy)
         for (int c = 0; c < NCH; c++) m_acc[c] = '0;
      if (wr && wch < NCH) begin
         if (OFF_EN && ws) m_off[wch] = wd;
         else              m_inc[wch] = wd;
      end
   endtask

   // ---------------- monitor ----------------
   int mon_cnt = 0;
   always @(posedge clk) if (reset_n && ce) mon_cnt++;

   always @(negedge clk) begin
      if (reset_n && ce) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("latency", 32'(mon_cnt), 32'(e.due));
               chk("out_ch",  32'(out_ch),  32'(e.ch));
               chk("out_cos", 32'(out_cos), 32'(f_cos(e.ph)));
               chk("out_sin", 32'(out_sin), 32'(f_sin(e.ph)));
            end
         end else if (q.size() != 0 && q[0].due <= mon_cnt) begin
            exp_t e;
            e = q.pop_front();
            chk("missing_valid", 32'(out_valid), 32'd1);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic e, input logic [NCH-1:0] en, input logic wr = 1'b0,
                       input int wch = 0, input logic [PW-1:0] wd = '0,
                       input logic ws = 1'b0, input logic sy = 1'b0);
      ce = e; ch_en = en; cfg_wr = wr; cfg_ch = CW'(wch);
      cfg_data = wd; cfg_sel = ws; sync = sy;
      model_edge(e, en, wr, wch, wd, ws, sy);
      @(posedge clk);
      #1;
      chk("cor_phase", 32'(cor_phase), 32'(m_phase));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ce = 1'b0; ch_en = '0; cfg_wr = 1'b0; cfg_sel = 1'b0; sync = 1'b0;
      cfg_ch = '0; cfg_data = '0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_ch",    32'(out_ch),    32'd0);
      chk("rst_cor_phase", 32'(cor_phase), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [PW-1:0] inc_max;
      inc_max = '1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Basic round robin, inc = 100,200,300,400 written with ce low.
      for (int c = 0; c < NCH; c++) step(1'b0, '1, 1'b1, c, PW'((c + 1) * 100));
      for (int i = 1; i <= 30; i++) begin
         step(1'b1, '1);
         if (i == 2)  chk("ch1_phase0", 32'(cor_phase), 32'd0);
         if (i == 6)  chk("ch1_phase1", 32'(cor_phase), 32'd200);
         if (i == 10) chk("ch1_phase2", 32'(cor_phase), 32'd400);
      end

      // Alternate ch0/ch2, then no channel enabled until the pipe drains.
      repeat (12) step(1'b1, 4'b0101);
      repeat (L + 4) step(1'b1, 4'b0000);
      chk("drain_empty", 32'(q.size()), 32'd0);

      // ce toggling.
      for (int i = 0; i < 60; i++) step(1'(i % 2 == 0), '1);

      // Wrap of acc[0] and an increment write coinciding with an issue.
      step(1'b0, 4'b0001, 1'b1, 0, inc_max, 1'b0, 1'b1);
      step(1'b1, 4'b0001); chk("wrap0", 32'(cor_phase), 32'd0);
      step(1'b1, 4'b0001); chk("wrap1", 32'(cor_phase), 32'd524287);
      step(1'b1, 4'b0001, 1'b1, 0, PW'(5));
      chk("wrap2", 32'(cor_phase), 32'd524286);
      step(1'b1, 4'b0001); chk("wrap3", 32'(cor_phase), 32'd524285);
      step(1'b1, 4'b0001); chk("wrap4", 32'(cor_phase), 32'd2);

      // Sync with samples in flight, then async reset mid-stream.
      repeat (6) step(1'b1, '1);
      step(1'b1, '1, 1'b0, 0, '0, 1'b0, 1'b1);
      repeat (L + 6) step(1'b1, '1);
      do_reset();

`ifdef CORDIC_NCO_PHASE_OFFSET_EN
      step(1'b0, '0, 1'b1, 1, PW'(131072), 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'b0010);
         chk("off_phase", 32'(cor_phase), 32'd131072);
      end
`endif

      // Randomised traffic.
      for (int i = 0; i < 700; i++) begin
         step(1'($urandom_range(0, 3) != 0), NCH'($urandom),
              1'($urandom_range(0, 3) == 0), int'($urandom_range(0, NCH - 1)),
              PW'($urandom), 1'($urandom), 1'($urandom_range(0, 31) == 0));
      end
      repeat (L + 4) step(1'b1, '0);
      chk("final_drain", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
